// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
// Sequential 4-bit restoring divider with a start/busy/done handshake.
// One quotient bit is produced per clock. Every operation takes four
// iterations, including divide-by-zero, so the latency is fixed.
//
// Optional build macro: DIVIDER_SIGNED_EN
//   undefined : operands and results are unsigned, ovf is tied low
//   defined   : operands and results are two's complement; magnitudes are
//               divided unsigned and the signs are applied on the last
//               iteration; -8 / -1 raises ovf
// ---------------------------------------------------------------------------
module divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic       dbz,
    output logic       ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] cnt_q;

    // Working registers. The dividend register shifts left each iteration
    // and takes the new quotient bit in its LSB, so after the fourth
    // iteration it holds the quotient.
    logic [3:0] dividend_q;
    logic [3:0] divisor_q;
    logic [3:0] partRem_q;

    // Original dividend, needed to return r=a on divide-by-zero.
    logic [3:0] aOrig_q;

`ifdef DIVIDER_SIGNED_EN
    // Original divisor, needed for the sign of q and for overflow detection.
    logic [3:0] bOrig_q;
`endif

    // Registered outputs.
    logic [3:0] quot_q;
    logic [3:0] rem_q;
    logic       busy_q;
    logic       done_q;
    logic       dbz_q;
    logic       ovf_q;

    // Next values of one iteration and of the final result.
    logic [4:0] trialPart;
    logic       trialOk;
    logic [3:0] partRem_d;
    logic [3:0] dividend_d;
    logic [3:0] quot_d;
    logic [3:0] rem_d;
    logic       dbz_d;
    logic       ovf_d;

    // One restoring-division step. The 5-bit partial remainder is the old
    // remainder with the dividend MSB shifted in. When the subtraction
    // succeeds, the difference is smaller than the divisor and fits in 4
    // bits, so the low 4 bits of the modular difference are the exact result.
    always_comb begin
        trialPart  = {partRem_q, dividend_q[3]};
        trialOk    = (trialPart >= {1'b0, divisor_q});
        partRem_d  = trialOk ? (trialPart[3:0] - divisor_q) : trialPart[3:0];
        dividend_d = {dividend_q[2:0], trialOk};
    end

    // Result formatting on the last iteration: force the divide-by-zero
    // pattern, or in the signed build apply the signs to the magnitudes.
    always_comb begin
        quot_d = dividend_d;
        rem_d  = partRem_d;
        dbz_d  = 1'b0;
        ovf_d  = 1'b0;
        if (divisor_q == 4'd0) begin
            quot_d = 4'b1111;
            rem_d  = aOrig_q;
            dbz_d  = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            if (aOrig_q[3] ^ bOrig_q[3]) begin
                quot_d = 4'd0 - dividend_d;
            end
            if (aOrig_q[3]) begin
                rem_d = 4'd0 - partRem_d;
            end
            // -8 / -1 = +8 does not fit; the magnitude path already yields
            // 4'b1000 for the quotient and zero remainder.
            ovf_d = (aOrig_q == 4'b1000) && (bOrig_q == 4'b1111);
`endif
        end
    end

    // Control FSM with registered outputs. Reset aborts any operation and
    // clears every output. start is only honoured in IDLE, and the result
    // registers change only on the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            dividend_q <= 4'd0;
            divisor_q  <= 4'd0;
            partRem_q  <= 4'd0;
            aOrig_q    <= 4'd0;
`ifdef DIVIDER_SIGNED_EN
            bOrig_q    <= 4'd0;
`endif
            quot_q     <= 4'd0;
            rem_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef DIVIDER_SIGNED_EN
                        dividend_q <= a[3] ? (4'd0 - a) : a;
                        divisor_q  <= b[3] ? (4'd0 - b) : b;
                        bOrig_q    <= b;
`else
                        dividend_q <= a;
                        divisor_q  <= b;
`endif
                        aOrig_q    <= a;
                        partRem_q  <= 4'd0;
                        cnt_q      <= 2'd0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    partRem_q  <= partRem_d;
                    dividend_q <= dividend_d;
                    cnt_q      <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        quot_q  <= quot_d;
                        rem_q   <= rem_d;
                        dbz_q   <= dbz_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = quot_q;
    assign r    = rem_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
// Directed self-checking bench for divider: a table of operand pairs with
// hand-computed results, plus hand-written sequences for back-to-back
// operation with operand churn and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] expQ;
        logic [3:0] expR;
        logic       expDbz;
        logic       expOvf;
    } vec_t;

    vec_t vecs[12];

    divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation and wait for done (bounded). Returns the number of
    // edges from the start-sample edge to done, and whether busy stayed high
    // on every cycle before done.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                                 output int lat, output bit busyOk);
        @(negedge clk);
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        busyOk = (busy == 1'b1) && (done == 1'b0);
        lat    = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                if (busy) busyOk = 1'b0;
                break;
            end
            if (!busy) busyOk = 1'b0;
        end
    endtask

    // Fill the vector table with hand-computed results for the active build.
    task automatic fillTable();
`ifdef DIVIDER_SIGNED_EN
        vecs[0]  = '{4'd13, 4'd3,  4'b1111, 4'd0,    1'b0, 1'b0}; // -3/3
        vecs[1]  = '{4'd7,  4'd0,  4'b1111, 4'b0111, 1'b1, 1'b0}; // /0
        vecs[2]  = '{4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0}; // -7/2
        vecs[3]  = '{4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 1'b1}; // -8/-1
        vecs[4]  = '{4'd6,  4'd2,  4'd3,    4'd0,    1'b0, 1'b0};
        vecs[5]  = '{4'd15, 4'd4,  4'd0,    4'b1111, 1'b0, 1'b0}; // -1/4
        vecs[6]  = '{4'd9,  4'd9,  4'd1,    4'd0,    1'b0, 1'b0}; // -7/-7
        vecs[7]  = '{4'd0,  4'd5,  4'd0,    4'd0,    1'b0, 1'b0};
        vecs[8]  = '{4'd1,  4'd15, 4'b1111, 4'd0,    1'b0, 1'b0}; // 1/-1
        vecs[9]  = '{4'd15, 4'd15, 4'd1,    4'd0,    1'b0, 1'b0}; // -1/-1
        vecs[10] = '{4'd7,  4'b1101, 4'b1110, 4'd1,  1'b0, 1'b0}; // 7/-3
        vecs[11] = '{4'b1000, 4'd0, 4'b1111, 4'b1000, 1'b1, 1'b0}; // -8/0
`else
        vecs[0]  = '{4'd13, 4'd3,  4'd4,    4'd1,    1'b0, 1'b0};
        vecs[1]  = '{4'd7,  4'd0,  4'b1111, 4'b0111, 1'b1, 1'b0};
        vecs[2]  = '{4'd9,  4'd2,  4'd4,    4'd1,    1'b0, 1'b0};
        vecs[3]  = '{4'd8,  4'd15, 4'd0,    4'd8,    1'b0, 1'b0};
        vecs[4]  = '{4'd6,  4'd2,  4'd3,    4'd0,    1'b0, 1'b0};
        vecs[5]  = '{4'd15, 4'd4,  4'd3,    4'd3,    1'b0, 1'b0};
        vecs[6]  = '{4'd9,  4'd9,  4'd1,    4'd0,    1'b0, 1'b0};
        vecs[7]  = '{4'd0,  4'd5,  4'd0,    4'd0,    1'b0, 1'b0};
        vecs[8]  = '{4'd1,  4'd15, 4'd0,    4'd1,    1'b0, 1'b0};
        vecs[9]  = '{4'd15, 4'd15, 4'd1,    4'd0,    1'b0, 1'b0};
        vecs[10] = '{4'd15, 4'd1,  4'd15,   4'd0,    1'b0, 1'b0};
        vecs[11] = '{4'd0,  4'd0,  4'b1111, 4'd0,    1'b1, 1'b0};
`endif
    endtask

    // Main sequence.
    initial begin
        int  lat;
        bit  busyOk;
        logic [3:0] expQ1, expR1, expQ2, expR2;

        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        fillTable();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset q",    q,    0);
        checkOutput("reset r",    r,    0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset dbz",  dbz,  0);
        checkOutput("reset ovf",  ovf,  0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat, busyOk);
            checkOutput($sformatf("vec%0d latency", i), lat, 4);
            checkOutput($sformatf("vec%0d busy", i), int'(busyOk), 1);
            checkOutput($sformatf("vec%0d q", i),   q,   vecs[i].expQ);
            checkOutput($sformatf("vec%0d r", i),   r,   vecs[i].expR);
            checkOutput($sformatf("vec%0d dbz", i), dbz, vecs[i].expDbz);
            checkOutput($sformatf("vec%0d ovf", i), ovf, vecs[i].expOvf);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done drop", i), done, 0);
        end

        // Back-to-back 15/4 then 9/9 with start held high and operand churn.
`ifdef DIVIDER_SIGNED_EN
        expQ1 = 4'd0; expR1 = 4'b1111; expQ2 = 4'd1; expR2 = 4'd0;
`else
        expQ1 = 4'd3; expR1 = 4'd3;    expQ2 = 4'd1; expR2 = 4'd0;
`endif
        @(negedge clk);
        a     = 4'd15;
        b     = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b first busy", busy, 1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            @(posedge clk);
            #1;
        end
        checkOutput("b2b first done", done, 1);
        checkOutput("b2b first q", q, expQ1);
        checkOutput("b2b first r", r, expR1);
        @(negedge clk);
        a = 4'd9;
        b = 4'd9;
        @(posedge clk);
        #1;
        checkOutput("b2b accept busy", busy, 1);
        checkOutput("b2b accept done", done, 0);
        checkOutput("b2b hold q", q, expQ1);
        checkOutput("b2b hold r", r, expR1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            @(posedge clk);
            #1;
            if (n < 4) checkOutput($sformatf("b2b second early done %0d", n), done, 0);
        end
        checkOutput("b2b second done", done, 1);
        checkOutput("b2b second q", q, expQ2);
        checkOutput("b2b second r", r, expR2);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b2b idle busy", busy, 0);

        // Reset in the middle of an operation: 13/3 started, rst at edge k+2.
        @(negedge clk);
        a     = 4'd13;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst q",    q,    0);
        checkOutput("midrst r",    r,    0);
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst done", done, 0);
        checkOutput("midrst dbz",  dbz,  0);
        checkOutput("midrst ovf",  ovf,  0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit sawDone;
            sawDone = 1'b0;
            for (int n = 0; n < 6; n++) begin
                @(posedge clk);
                #1;
                if (done || busy) sawDone = 1'b1;
            end
            checkOutput("midrst no done", int'(sawDone), 0);
        end
        applyStimulus(4'd6, 4'd2, lat, busyOk);
        checkOutput("after rst latency", lat, 4);
        checkOutput("after rst q", q, 3);
        checkOutput("after rst r", r, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
